key_debounce_pulse: RTL and testbench

- Upstream front-end for the board-level event counters.
- Synchronises a raw mechanical push-button and debounces it.
- Emits a clean debounced level plus single-cycle press/release pulses.
- press_pulse drives a downstream counter's increment enable, giving one increment per physical press.

---
 rtl/key_pkg.sv | 26 ++
 rtl/sync_2ff.sv | 31 +++
 rtl/key_debounce_pulse.sv | 160 ++++++++++++++++
 tb/tb_key_debounce_pulse.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared constants for the push-button debounce front-end
//
// Purpose : FSM state encodings, default debounce depths and a small helper
//           used by key_debounce_pulse to sanity-check its configuration.
// Ports   : none (package).

package key_pkg;

    localparam logic [1:0] KEY_IDLE        = 2'd0;
    localparam logic [1:0] KEY_PRESS_DEB   = 2'd1;
    localparam logic [1:0] KEY_HELD        = 2'd2;
    localparam logic [1:0] KEY_RELEASE_DEB = 2'd3;

    // Short depth keeps simulation fast; board builds need ~20 ms at the system clock.
    localparam int unsigned KEY_DEB_CYCLES_SIM   = 20;
    localparam int unsigned KEY_DEB_CYCLES_BOARD = 1_000_000;

    function automatic int unsigned key_max3(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for asynchronous board inputs
//
// Purpose : brings an asynchronous level into the clk domain.
// Ports   : clk, rst_n (async, active-low), d (async in), q (synchronised out).
// RESET_VAL is the idle level of the input so reset never fakes an event.

module sync_2ff #(
    parameter bit RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/key_debounce_pulse.sv
// rtl/key_debounce_pulse.sv - push-button synchroniser, debouncer and press/release pulser
//
// Purpose : turns a bouncing mechanical key into a clean pressed level plus
//           one-cycle press/release strobes (press_pulse feeds a counter enable).
// Ports   : clk, rst_n (async, active-low), key_in (raw key),
//           key_level (1 = pressed), press_pulse, release_pulse (all registered).
// Config  : define KEY_AUTOREPEAT_EN to re-fire press_pulse while the key is held
//           (first after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles).

module key_debounce_pulse
    import key_pkg::*;
#(
    parameter int unsigned DEB_CYCLES     = 20,
    parameter int unsigned CNT_W          = 20,
    parameter bit          KEY_ACTIVE_LOW = 1'b0,
    parameter int unsigned REPEAT_DELAY   = 50,
    parameter int unsigned REPEAT_PERIOD  = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int unsigned CNT_NEED = key_max3(DEB_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);

    // Counters are never allowed to wrap, so an undersized CNT_W is rejected outright.
    if ((DEB_CYCLES < 2) || (CNT_W < $clog2(CNT_NEED + 1))) begin : g_bad_cfg
        $error("key_debounce_pulse: DEB_CYCLES must be >= 2 and CNT_W must hold the largest count");
    end

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic key_sync;
    logic k_s;

    sync_2ff #(
        .RESET_VAL (KEY_ACTIVE_LOW)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (key_in),
        .q     (key_sync)
    );

    // Normalise to 1 = pressed after synchronisation.
    assign k_s = key_sync ^ KEY_ACTIVE_LOW;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

`ifdef KEY_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] RPT_FIRE   = CNT_W'(REPEAT_DELAY - 1);
    // Reloading to DELAY-PERIOD makes the next fire land PERIOD cycles later.
    localparam logic [CNT_W-1:0] RPT_RELOAD = CNT_W'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [CNT_W-1:0] rpt_q, rpt_d;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
        rpt_d     = rpt_q;
`endif
        case (state_q)
            KEY_IDLE: begin
                if (k_s) begin
                    state_d = KEY_PRESS_DEB;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            KEY_PRESS_DEB: begin
                if (!k_s) begin
                    state_d = KEY_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = KEY_HELD;
                    level_d = 1'b1;
                    press_d = 1'b1;
                    cnt_d   = '0;
`ifdef KEY_AUTOREPEAT_EN
                    rpt_d   = '0;
`endif
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            KEY_HELD: begin
                if (!k_s) begin
                    state_d = KEY_RELEASE_DEB;
                    cnt_d   = CNT_ONE;
`ifdef KEY_AUTOREPEAT_EN
                    rpt_d   = '0;
                end else if (rpt_q == RPT_FIRE) begin
                    press_d = 1'b1;
                    rpt_d   = RPT_RELOAD;
                end else begin
                    rpt_d   = rpt_q + CNT_ONE;
`endif
                end
            end
            default: begin
                if (k_s) begin
                    state_d   = KEY_HELD;
                    cnt_d     = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d   = KEY_IDLE;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d     = cnt_q + CNT_ONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= KEY_IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

`ifdef KEY_AUTOREPEAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_q <= '0;
        end else begin
            rpt_q <= rpt_d;
        end
    end
`endif

    assign key_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

endmodule

// File: tb/tb_key_debounce_pulse.sv
// tb/tb_key_debounce_pulse.sv - self-checking bench for key_debounce_pulse

module tb_key_debounce_pulse;

    localparam int DEB = 4;
    localparam int CW  = 8;
    localparam int RD  = 8;
    localparam int RP  = 3;

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic key_raw   = 1'b0;
    logic key_raw_n = 1'b1;

    logic lvl_h, prs_h, rel_h;
    logic lvl_l, prs_l, rel_l;

    always #5 clk = ~clk;

    key_debounce_pulse #(
        .DEB_CYCLES (DEB), .CNT_W (CW), .KEY_ACTIVE_LOW (1'b0),
        .REPEAT_DELAY (RD), .REPEAT_PERIOD (RP)
    ) dut_h (
        .clk (clk), .rst_n (rst_n), .key_in (key_raw),
        .key_level (lvl_h), .press_pulse (prs_h), .release_pulse (rel_h)
    );

    key_debounce_pulse #(
        .DEB_CYCLES (DEB), .CNT_W (CW), .KEY_ACTIVE_LOW (1'b1),
        .REPEAT_DELAY (RD), .REPEAT_PERIOD (RP)
    ) dut_l (
        .clk (clk), .rst_n (rst_n), .key_in (key_raw_n),
        .key_level (lvl_l), .press_pulse (prs_l), .release_pulse (rel_l)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference model: pressed level changes once the last DEB samples seen by the
    // debouncer all disagree with it; those samples are key_in delayed two edges.
    bit m_s1, m_s2, m_prev, m_lvl, m_prs, m_rel;
    int m_age;
    bit hist[$];

    int cyc = 0;
    int rel_cnt = 0;
    int press_times[$];
    int rel_times[$];

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_prev = 0; m_lvl = 0; m_prs = 0; m_rel = 0; m_age = 0;
        hist.delete();
    endtask

    task automatic model_edge(input bit k);
        bit ks;
        bit all_diff;
        ks   = m_s2;
        m_s2 = m_s1;
        m_s1 = k;
        hist.push_back(ks);
        if (hist.size() > DEB) void'(hist.pop_front());
        m_prs = 0;
        m_rel = 0;
        all_diff = (hist.size() == DEB);
        foreach (hist[i]) if (hist[i] == m_lvl) all_diff = 0;
        if (all_diff) begin
            m_lvl = !m_lvl;
            if (m_lvl) m_prs = 1; else m_rel = 1;
            m_age = 0;
            hist.delete();
        end
`ifdef KEY_AUTOREPEAT_EN
        else if (m_lvl) begin
            // Held-cycle age restarts whenever the key dips or has just come back.
            if (!ks || !m_prev) m_age = 0;
            else begin
                m_age++;
                if (m_age >= RD && ((m_age - RD) % RP) == 0) m_prs = 1;
            end
        end
`endif
        m_prev = ks;
    endtask

    task automatic cycle(input bit k);
        key_raw   = k;
        key_raw_n = !k;
        @(posedge clk);
        model_edge(k);
        cyc++;
        @(negedge clk);
        chk("lvl_h", lvl_h, m_lvl);
        chk("prs_h", prs_h, m_prs);
        chk("rel_h", rel_h, m_rel);
        chk("lvl_l", lvl_l, m_lvl);
        chk("prs_l", prs_l, m_prs);
        chk("rel_l", rel_l, m_rel);
        if (prs_h) press_times.push_back(cyc);
        if (rel_h) begin rel_cnt++; rel_times.push_back(cyc); end
    endtask

    task automatic hold(input bit k, input int n);
        for (int i = 0; i < n; i++) cycle(k);
    endtask

    // Asserts reset mid-cycle, checks outputs clear at once, then releases it at a negedge.
    task automatic apply_reset(input bit k, input int n);
        #2;
        rst_n     = 1'b0;
        key_raw   = k;
        key_raw_n = !k;
        #1;
        chk("rst_lvl_h", lvl_h, 0);
        chk("rst_prs_h", prs_h, 0);
        chk("rst_rel_h", rel_h, 0);
        chk("rst_lvl_l", lvl_l, 0);
        chk("rst_prs_l", prs_l, 0);
        chk("rst_rel_l", rel_l, 0);
        model_reset();
        for (int i = 0; i < n; i++) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int c0;
    int exp_off[5] = '{0, 8, 11, 14, 17};

    initial begin
        model_reset();
        @(negedge clk);
        apply_reset(1'b0, 2);

        // Clean press: pulse 5 edges after the first pressed sample.
        hold(0, 3);
        c0 = cyc + 1;
        press_times.delete();
        hold(1, 20);
        chk("t1_npress", press_times.size() >= 1, 1);
        if (press_times.size() >= 1) chk("t1_lat", press_times[0] - c0, DEB + 1);
        chk("t1_lvl", lvl_h, 1);
        chk("t5_lvl_l", lvl_l, 1);

        // Clean release.
        c0 = cyc + 1;
        rel_times.delete();
        hold(0, 10);
        chk("t3_nrel", rel_times.size(), 1);
        if (rel_times.size() >= 1) chk("t3_rel_lat", rel_times[0] - c0, DEB + 1);
        chk("t3_lvl0", lvl_h, 0);

        // Bounce then stable press.
        press_times.delete();
        hold(1, 1); hold(0, 1); hold(1, 2); hold(0, 1);
        c0 = cyc + 1;
        hold(1, 10);
        chk("t2_npress", press_times.size(), 1);
        if (press_times.size() >= 1) chk("t2_lat", press_times[0] - c0, DEB + 1);

        // Short release glitch while held.
        rel_cnt = 0;
        hold(0, 2);
        hold(1, 10);
        chk("t3_glitch_rel", rel_cnt, 0);
        chk("t3_glitch_lvl", lvl_h, 1);

        // Reset while held, then reset mid press-debounce, key held throughout.
        apply_reset(1'b1, 2);
        hold(0, 10);
        hold(1, 4);
        apply_reset(1'b1, 3);
        c0 = cyc + 1;
        press_times.delete();
        hold(1, 10);
        chk("t4_npress", press_times.size(), 1);
        if (press_times.size() >= 1) chk("t4_lat", press_times[0] - c0, DEB + 1);

`ifdef KEY_AUTOREPEAT_EN
        hold(0, 10);
        press_times.delete();
        c0 = cyc + 1;
        hold(1, DEB + 1 + 18);
        hold(0, 10);
        chk("t6_npress", press_times.size(), 5);
        if (press_times.size() == 5)
            for (int i = 0; i < 5; i++) chk("t6_off", press_times[i] - press_times[0], exp_off[i]);
`endif

        // Randomised runs of random length, with occasional resets.
        for (int seg = 0; seg < 400; seg++) begin
            if ($urandom_range(0, 39) == 0) apply_reset(1'($urandom_range(0, 1)), $urandom_range(1, 3));
            hold(1'($urandom_range(0, 1)), $urandom_range(1, DEB + 4));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
